fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 16-bit fifo between two producers with req/ack handshakes.
//  Ownership is granted round-robin with a bounded burst length.
//  Write strobe and data to the fifo are registered; fifo status drives backpressure.
//  Sits between producer blocks and the fifo; also keeps sticky error and per-requester word counts.
// PARAMETERS
//  WIDTH     16  data width of producers and fifo din
//  MAXBURST  4   max words written per grant before ownership is re-arbitrated (>=1)
//  CNTW      16  width of per-requester word counters
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  req0        in   1      producer 0 has a word on din0
//  din0        in   WIDTH  producer 0 data
//  ack0        out  1      comb; word on din0 accepted at this edge
//  req1        in   1      producer 1 has a word on din1
//  din1        in   WIDTH  producer 1 data
//  ack1        out  1      comb; word on din1 accepted at this edge
//  fifo_wr     out  1      registered write strobe to fifo
//  fifo_din    out  WIDTH  registered write data to fifo
//  fifo_almostfull in 1    fifo holds DEPTH-1 words
//  fifo_full   in   1      fifo holds DEPTH words
//  fifo_over   in   1      fifo overflow pulse
//  fifo_under  in   1      fifo underflow pulse
//  clr_err     in   1      sync clear of err
//  err         out  1      sticky: any fifo_over/fifo_under seen
//  grant       out  2      one-hot current owner (00 = idle)
//  wcnt0       out  CNTW   words accepted from producer 0, wraps
//  wcnt1       out  CNTW   words accepted from producer 1, wraps
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, last=1, beat=0, fifo_wr=0, fifo_din=0, err=0, wcnt0=wcnt1=0;
//    ack0=ack1=0 and grant=00 follow immediately.
//  FSM states: IDLE, OWN0, OWN1.
//    IDLE: req0&(!req1|last==1) -> OWN0; else req1 -> OWN1; else stay. No ack in IDLE (1-cycle bubble).
//    OWNn: ackn = reqn & !stall. stall = fifo_full | (fifo_almostfull & fifo_wr).
//    Release OWNn when !reqn, or on ack with beat==MAXBURST-1.
//    On release: other req high -> OWN(other) directly, else IDLE. last<=n on release.
//    beat increments on each ack, clears on any state change; stall holds beat and state.
//  Data path: on ackn edge fifo_din<=dinn, fifo_wr<=1; otherwise fifo_wr<=0, fifo_din holds.
//    Write reaches fifo 1 cycle after ack; stall accounts for that in-flight word.
//  Throughput: 1 word/cycle within a grant; no bubble on OWN0<->OWN1 handover.
//  err: set when fifo_over|fifo_under; set beats clr_err in the same cycle.
//  wcntN: +1 per ackN, wraps 2^CNTW-1 -> 0.
//  Fairness: both requesting continuously -> bursts of exactly MAXBURST alternate (absent stall).
//  req dropped mid-burst: release next edge, no ack that cycle.
//  rst asserted mid-burst: in-flight fifo_wr cleared immediately; the word is lost (no replay).
// TESTING
//  Reset: rst=0 with req0=req1=1 -> ack0=ack1=0, fifo_wr=0, grant=00, err=0, wcnt=0.
//  Single producer: req0 held for 6 words 0x0001..0x0006, MAXBURST=4
//    -> grant 01, 1-cycle bubble after word 4 (IDLE), wcnt0=6, fifo sees 1..6 in order.
//  Contention: req0=req1=1 from reset, MAXBURST=4 -> order P0x4, P1x4, P0x4; no gap at handovers.
//  Backpressure: fifo_almostfull=1 after a write -> next ack suppressed; fifo_full=1 -> acks held;
//    beat frozen; resumes on release.
//  Errors: fifo_over 1-cycle pulse -> err=1 until clr_err. over and clr_err same cycle -> err stays 1.
//  Mid-burst reset: rst=0 during OWN1 beat 2 -> fifo_wr=0 at once;
//    after release, a tie grants P0 first (last=1).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one registered fifo write port between two producers.
// Bursts are capped at MAXBURST words. The block also keeps a sticky error flag and per-producer word counts.
module fifo_wr_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAXBURST = 4,
  parameter int CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack1,
  output logic             fifo_wr,
  output logic [WIDTH-1:0] fifo_din,
  input  logic             fifo_almostfull,
  input  logic             fifo_full,
  input  logic             fifo_over,
  input  logic             fifo_under,
  input  logic             clr_err,
  output logic             err,
  output logic [1:0]       grant,
  output logic [CNTW-1:0]  wcnt0,
  output logic [CNTW-1:0]  wcnt1
);

  localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);

  // The state encoding is the one-hot grant, so grant doubles as the FSM debug view.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic          stall;

  // The registered word already on its way counts against an almost-full fifo.
  assign stall = fifo_full | (fifo_almostfull & fifo_wr);
  assign grant = state;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) state_nxt = OWN0;
        else if (req1)               state_nxt = OWN1;
      end
      OWN0: begin
        ack0 = req0 & ~stall;
        if (!req0 || (ack0 && beat == LAST_BEAT)) begin
          state_nxt = req1 ? OWN1 : IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        ack1 = req1 & ~stall;
        if (!req1 || (ack1 && beat == LAST_BEAT)) begin
          state_nxt = req0 ? OWN0 : IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    beat_nxt = beat;
    if (state_nxt != state)  beat_nxt = '0;
    else if (ack0 || ack1)   beat_nxt = beat + BW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      beat  <= beat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
    end else begin
      fifo_wr <= ack0 | ack1;
      if (ack0)      fifo_din <= din0;
      else if (ack1) fifo_din <= din1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err   <= 1'b0;
      wcnt0 <= '0;
      wcnt1 <= '0;
    end else begin
      if (fifo_over || fifo_under) err <= 1'b1;
      else if (clr_err)            err <= 1'b0;
      if (ack0) wcnt0 <= wcnt0 + CNTW'(1);
      if (ack1) wcnt1 <= wcnt1 + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic.
// The DUT is compared against a transaction-level reference model and an expected-data queue.
module tb_fifo_wr_arbiter;

  localparam int WIDTH    = 16;
  localparam int MAXBURST = 4;
  localparam int CNTW     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic             ack0, ack1;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_almostfull = 1'b0, fifo_full = 1'b0;
  logic             fifo_over = 1'b0, fifo_under = 1'b0, clr_err = 1'b0;
  logic             err;
  logic [1:0]       grant;
  logic [CNTW-1:0]  wcnt0, wcnt1;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .ack0(ack0),
    .req1(req1), .din1(din1), .ack1(ack1),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_almostfull(fifo_almostfull), .fifo_full(fifo_full),
    .fifo_over(fifo_over), .fifo_under(fifo_under),
    .clr_err(clr_err), .err(err), .grant(grant),
    .wcnt0(wcnt0), .wcnt1(wcnt1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and counters
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // reference model: owner -1 means nobody holds the port
  int              m_owner;
  int              m_last;
  int              m_words;
  bit              m_wr;
  bit              m_err;
  logic [CNTW-1:0] m_cnt0, m_cnt1;

  // producer data sources and DUT samples from the latest cycle
  logic [WIDTH-1:0] p0_word, p1_word;
  logic [1:0]       s_grant;
  logic             s_err;
  logic [CNTW-1:0]  s_wcnt0;
  int               dut_acks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_words = 0;
    m_wr    = 1'b0;
    m_err   = 1'b0;
    m_cnt0  = '0;
    m_cnt1  = '0;
    exp_q.delete();
  endtask

  // Assert reset while both producers request. Check the reset outputs, then release reset with quiet inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_ack1", ack1, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_fifo_wr", fifo_wr, 0);
    check_eq("rst_fifo_din", fifo_din, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wcnt0", wcnt0, 0);
    check_eq("rst_wcnt1", wcnt1, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    fifo_almostfull = 1'b0; fifo_full = 1'b0;
    fifo_over = 1'b0; fifo_under = 1'b0; clr_err = 1'b0;
  endtask

  // One clock: drive the inputs, compare the DUT against the model, then advance the model across the next edge.
  task automatic cycle(input bit r0, input bit r1, input bit af, input bit fl,
                       input bit ov, input bit un, input bit cl);
    bit stall, e_ack0, e_ack1, rel;
    logic [1:0] e_grant;
    int n;
    @(negedge clk);
    req0 = r0; req1 = r1; din0 = p0_word; din1 = p1_word;
    fifo_almostfull = af; fifo_full = fl;
    fifo_over = ov; fifo_under = un; clr_err = cl;
    #1;
    stall   = fl || (af && m_wr);
    e_ack0  = (m_owner == 0) && r0 && !stall;
    e_ack1  = (m_owner == 1) && r1 && !stall;
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;

    check_eq("ack0", ack0, e_ack0);
    check_eq("ack1", ack1, e_ack1);
    check_eq("grant", grant, e_grant);
    check_eq("fifo_wr", fifo_wr, m_wr);
    check_eq("err", err, m_err);
    check_eq("wcnt0", wcnt0, m_cnt0);
    check_eq("wcnt1", wcnt1, m_cnt1);
    if (fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_wr", fifo_wr, 0);
      else                   check_eq("fifo_din", fifo_din, exp_q.pop_front());
    end
    s_grant = grant; s_err = err; s_wcnt0 = wcnt0;
    if (ack0 || ack1) dut_acks++;

    m_wr = e_ack0 || e_ack1;
    if (e_ack0) begin exp_q.push_back(p0_word); m_cnt0++; p0_word++; end
    if (e_ack1) begin exp_q.push_back(p1_word); m_cnt1++; p1_word++; end
    if (ov || un) m_err = 1'b1;
    else if (cl)  m_err = 1'b0;

    if (m_owner < 0) begin
      if (r0 && (!r1 || m_last == 1)) m_owner = 0;
      else if (r1)                    m_owner = 1;
      m_words = 0;
    end else begin
      n   = m_owner;
      rel = 1'b0;
      if (!(n == 0 ? r0 : r1)) rel = 1'b1;
      else if (e_ack0 || e_ack1) begin
        m_words++;
        if (m_words == MAXBURST) rel = 1'b1;
      end
      if (rel) begin
        m_last  = n;
        m_words = 0;
        if (n == 0) m_owner = r1 ? 1 : -1;
        else        m_owner = r0 ? 0 : -1;
      end
    end
  endtask

  initial begin
    int a;
    bit r0, r1;
    p0_word = '0; p1_word = '0;
    s_grant = '0; s_err = 1'b0; s_wcnt0 = '0;
    model_reset();

    // single producer: six words with one bubble after the fourth
    do_reset();
    p0_word = 16'h0001;
    for (int i = 0; i < 30 && p0_word <= 16'h0006; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_eq("single_wcnt0", s_wcnt0, 6);

    // contention: alternating bursts of four with no gap at the handovers
    do_reset();
    p0_word = 16'h0100; p1_word = 16'h0200;
    cycle(1, 1, 0, 0, 0, 0, 0);
    a = dut_acks;
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    check_eq("contention_nogap", dut_acks - a, 12);
    check_eq("contention_third_p0", s_grant, 2'b01);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // backpressure: almost-full then full
    do_reset();
    p0_word = 16'h0A00;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // sticky error, set winning over clear
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_eq("err_sticky", s_err, 1);
    cycle(0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_eq("err_set_beats_clr", s_err, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check_eq("err_cleared", s_err, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // reset during OWN1 beat 2: word in flight is dropped, then a tie goes to P0
    do_reset();
    p1_word = 16'h0B00;
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_eq("tie_after_reset_p0", s_grant, 2'b01);

    // random traffic
    r0 = 1'b0; r1 = 1'b0;
    p0_word = 16'($urandom); p1_word = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      cycle(r0, r1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) == 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
